// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial datapath: state encodings, default width, adder helper.
// Used by both the receive-side adder and the transmit-side serialiser FSM.
package bit_serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam int BSRX_SIZE = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register, LSB-first: new bits enter at the MSB and shift right.
// 'shifted' is the contents as they will be after the pending shift, so a parent can capture a full word on the final bit.
module sipo_shift_reg
    import bit_serial_pkg::*;
#(
    parameter int SIZE = BSRX_SIZE
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            en,
    input  logic            din,
    output logic [SIZE-1:0] shifted
);

    logic [SIZE-1:0] data;

    generate
        if (SIZE == 1) begin : g_one
            assign shifted = din;
        end else begin : g_many
            assign shifted = {din, data[SIZE-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            data <= '0;
        end else if (en) begin
            data <= shifted;
        end
    end

endmodule

// File: rtl/bit_serial_rx_adder.sv
// Bit-serial receive adder: adds two LSB-first streams with one full adder and a carry flop,
// deserialises the SIZE+1-bit sum and offers it on a valid/ready handshake.
// Optional BSRX_SIGNED_OVF_EN adds a registered two's-complement overflow flag (OVF).
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for FRAME_START with BIT_VALID
// S_RECV | frame in progress, capturing one bit per BIT_VALID
// S_HOLD | SUM complete and valid, waiting for SUM_READY
module bit_serial_rx_adder
    import bit_serial_pkg::*;
#(
    parameter int SIZE = BSRX_SIZE
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          FRAME_START,
    input  logic          BIT_VALID,
    input  logic          A_BIT,
    input  logic          B_BIT,
    output logic [SIZE:0] SUM,
    output logic          SUM_VALID,
    input  logic          SUM_READY,
    output logic          BUSY,
    output logic          FRAME_ERR,
`ifdef BSRX_SIGNED_OVF_EN
    output logic          OVERRUN,
    output logic          OVF
`else
    output logic          OVERRUN
`endif
);

    localparam int              CW       = $clog2(SIZE + 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(SIZE - 1);

    state_t          state_q;
    state_t          state_n;
    logic            carry_q;
    logic [CW-1:0]   count_q;

    logic            capture;
    logic            start;
    logic            frame_err_n;
    logic            overrun_n;

    logic            cin;
    logic            s;
    logic            c_next;
    logic [CW-1:0]   idx;
    logic            last;
    logic [SIZE-1:0] sr_next;

    always_comb begin
        state_n     = state_q;
        capture     = 1'b0;
        start       = 1'b0;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (BIT_VALID && FRAME_START) begin
                    capture = 1'b1;
                    start   = 1'b1;
                end
            end
            S_RECV: begin
                if (BIT_VALID) begin
                    capture = 1'b1;
                    if (FRAME_START) begin
                        start       = 1'b1;
                        frame_err_n = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (SUM_READY) begin
                    state_n = S_IDLE;
                    // a new frame may begin on the handshake cycle itself
                    if (BIT_VALID && FRAME_START) begin
                        capture = 1'b1;
                        start   = 1'b1;
                    end
                end else if (BIT_VALID) begin
                    overrun_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (capture) begin
            state_n = last ? S_HOLD : S_RECV;
        end
    end

    always_comb begin
        cin    = start ? 1'b0 : carry_q;
        s      = A_BIT ^ B_BIT ^ cin;
        c_next = maj3(A_BIT, B_BIT, cin);
        idx    = start ? '0 : count_q;
        last   = (idx == LAST_IDX);
    end

    sipo_shift_reg #(.SIZE(SIZE)) u_sipo (
        .clk     (CLK),
        .clr     (RST),
        .en      (capture),
        .din     (s),
        .shifted (sr_next)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            carry_q   <= 1'b0;
            count_q   <= '0;
            SUM       <= '0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
`ifdef BSRX_SIGNED_OVF_EN
            OVF       <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            FRAME_ERR <= frame_err_n;
            OVERRUN   <= overrun_n;
            if (capture) begin
                carry_q <= last ? 1'b0 : c_next;
                count_q <= last ? '0 : idx + CW'(1);
                if (last) begin
                    SUM <= {c_next, sr_next};
`ifdef BSRX_SIGNED_OVF_EN
                    OVF <= cin ^ c_next;
`endif
                end
            end
        end
    end

    assign SUM_VALID = (state_q == S_HOLD);
    assign BUSY      = (state_q == S_RECV);

endmodule

// File: tb/tb_bit_serial_rx_adder.sv
// Self-checking bench for bit_serial_rx_adder (SIZE=8): directed scenarios plus randomized frames
// checked against plain integer addition. Define BSRX_SIGNED_OVF_EN to also exercise OVF.
module tb_bit_serial_rx_adder;

    localparam int SIZE = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          FRAME_START;
    logic          BIT_VALID;
    logic          A_BIT;
    logic          B_BIT;
    logic [SIZE:0] SUM;
    logic          SUM_VALID;
    logic          SUM_READY;
    logic          BUSY;
    logic          FRAME_ERR;
    logic          OVERRUN;
`ifdef BSRX_SIGNED_OVF_EN
    logic          OVF;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int r_early;
    int r_fe_first;
    int r_fe_total;
    int r_busy_bad;

    bit_serial_rx_adder #(.SIZE(SIZE)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .FRAME_START (FRAME_START),
        .BIT_VALID   (BIT_VALID),
        .A_BIT       (A_BIT),
        .B_BIT       (B_BIT),
        .SUM         (SUM),
        .SUM_VALID   (SUM_VALID),
        .SUM_READY   (SUM_READY),
        .BUSY        (BUSY),
        .FRAME_ERR   (FRAME_ERR),
`ifdef BSRX_SIGNED_OVF_EN
        .OVERRUN     (OVERRUN),
        .OVF         (OVF)
`else
        .OVERRUN     (OVERRUN)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [SIZE:0] sum_model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic ovf_model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        return (s > 127) || (s < -128);
    endfunction

    // one clock: inputs set at negedge, outputs observed 1 time unit after posedge
    task automatic cyc(input logic fs, input logic bv, input logic a, input logic b);
        @(negedge CLK);
        FRAME_START = fs;
        BIT_VALID   = bv;
        A_BIT       = a;
        B_BIT       = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bits(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                             input int lo, input int hi, input logic fs_lo, input int max_stall);
        r_early = 0; r_fe_first = 0; r_fe_total = 0; r_busy_bad = 0;
        for (int i = lo; i <= hi; i++) begin
            if (i != lo) begin
                int ns;
                ns = int'($urandom_range(max_stall, 0));
                repeat (ns) begin
                    cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom));
                    if (SUM_VALID) r_early++;
                    if (!BUSY) r_busy_bad++;
                    if (FRAME_ERR) r_fe_total++;
                end
            end
            cyc((i == lo) ? fs_lo : 1'b0, 1'b1, a[i], b[i]);
            if (i == lo && FRAME_ERR) r_fe_first = 1;
            if (FRAME_ERR) r_fe_total++;
            if (i != SIZE - 1) begin
                if (SUM_VALID) r_early++;
                if (!BUSY) r_busy_bad++;
            end
        end
    endtask

    task automatic drain();
        SUM_READY = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        SUM_READY = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        n_cmp++; if (SUM !== 9'h000) begin n_bad++; $display("FAIL reset_sum: got %h want %h", SUM, 9'h000); end
        n_cmp++; if (SUM_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", SUM_VALID); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_cmp++; if (FRAME_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", FRAME_ERR); end
        n_cmp++; if (OVERRUN !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", OVERRUN); end
        // a valid bit with no FRAME_START in IDLE is ignored
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL idle_ignore_busy: got %b want 0", BUSY); end
        n_cmp++; if (SUM_VALID !== 1'b0) begin n_bad++; $display("FAIL idle_ignore_valid: got %b want 0", SUM_VALID); end
    endtask

    task automatic test_basic();
        SUM_READY = 1'b0;
        send_bits(8'h5A, 8'h3C, 0, 7, 1'b1, 0);
        n_cmp++; if (SUM_VALID !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", SUM_VALID); end
        n_cmp++; if (SUM !== 9'h096) begin n_bad++; $display("FAIL basic_sum: got %h want %h", SUM, 9'h096); end
        n_cmp++; if (r_early !== 0) begin n_bad++; $display("FAIL basic_early_valid: got %0d want 0", r_early); end
        n_cmp++; if (r_busy_bad !== 0) begin n_bad++; $display("FAIL basic_busy: got %0d bad cycles want 0", r_busy_bad); end
        n_cmp++; if (r_fe_total !== 0) begin n_bad++; $display("FAIL basic_frame_err: got %0d want 0", r_fe_total); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL basic_busy_hold: got %b want 0", BUSY); end
        drain();
        n_cmp++; if (SUM_VALID !== 1'b0) begin n_bad++; $display("FAIL basic_valid_clear: got %b want 0", SUM_VALID); end
        n_cmp++; if (SUM !== 9'h096) begin n_bad++; $display("FAIL basic_sum_kept: got %h want %h", SUM, 9'h096); end
    endtask

    task automatic test_stalls();
        SUM_READY = 1'b0;
        send_bits(8'hFF, 8'h01, 0, 7, 1'b1, 3);
        n_cmp++; if (SUM !== 9'h100) begin n_bad++; $display("FAIL stall_sum: got %h want %h", SUM, 9'h100); end
        n_cmp++; if (SUM_VALID !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b want 1", SUM_VALID); end
        n_cmp++; if (r_early !== 0) begin n_bad++; $display("FAIL stall_early_valid: got %0d want 0", r_early); end
        n_cmp++; if (r_busy_bad !== 0) begin n_bad++; $display("FAIL stall_busy: got %0d bad cycles want 0", r_busy_bad); end
        drain();
    endtask

    task automatic test_frame_err();
        SUM_READY = 1'b0;
        send_bits(8'h11, 8'h22, 0, 3, 1'b1, 0);
        send_bits(8'h0F, 8'h01, 0, 7, 1'b1, 0);
        n_cmp++; if (r_fe_first !== 1) begin n_bad++; $display("FAIL ferr_pulse: got %0d want 1", r_fe_first); end
        n_cmp++; if (r_fe_total !== 1) begin n_bad++; $display("FAIL ferr_width: got %0d pulse cycles want 1", r_fe_total); end
        n_cmp++; if (SUM !== 9'h010) begin n_bad++; $display("FAIL ferr_sum: got %h want %h", SUM, 9'h010); end
        n_cmp++; if (SUM_VALID !== 1'b1) begin n_bad++; $display("FAIL ferr_valid: got %b want 1", SUM_VALID); end
        drain();
    endtask

    task automatic test_overrun_back_to_back();
        logic [SIZE:0]   exp;
        logic [SIZE-1:0] a2;
        logic [SIZE-1:0] b2;
        int ov;
        int unstable;
        SUM_READY = 1'b0;
        exp = sum_model(8'hC3, 8'h5D);
        send_bits(8'hC3, 8'h5D, 0, 7, 1'b1, 1);
        ov = 0; unstable = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, (k == 1 || k == 3), 1'($urandom), 1'($urandom));
            if (OVERRUN) ov++;
            if (SUM !== exp || SUM_VALID !== 1'b1) unstable++;
        end
        n_cmp++; if (ov !== 2) begin n_bad++; $display("FAIL overrun_count: got %0d want 2", ov); end
        n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable); end
        a2 = 8'($urandom);
        b2 = 8'($urandom);
        SUM_READY = 1'b1;
        send_bits(a2, b2, 0, 7, 1'b1, 0);
        n_cmp++; if (SUM !== sum_model(a2, b2)) begin n_bad++; $display("FAIL b2b_sum: got %h want %h", SUM, sum_model(a2, b2)); end
        n_cmp++; if (SUM_VALID !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", SUM_VALID); end
        n_cmp++; if (r_early !== 0 || r_busy_bad !== 0) begin n_bad++; $display("FAIL b2b_recv: got early=%0d busy_bad=%0d want 0/0", r_early, r_busy_bad); end
        drain();
    endtask

    task automatic test_reset_mid_frame();
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        a = 8'hA5; b = 8'h5A;
        SUM_READY = 1'b0;
        send_bits(a, b, 0, 4, 1'b1, 0);
        RST = 1'b1;
        cyc(1'b0, 1'b1, a[5], b[5]);
        RST = 1'b0;
        n_cmp++; if (SUM !== 9'h000) begin n_bad++; $display("FAIL midrst_sum: got %h want %h", SUM, 9'h000); end
        n_cmp++; if (SUM_VALID !== 1'b0 || BUSY !== 1'b0) begin n_bad++; $display("FAIL midrst_state: got valid=%b busy=%b want 0/0", SUM_VALID, BUSY); end
        n_cmp++; if (FRAME_ERR !== 1'b0 || OVERRUN !== 1'b0) begin n_bad++; $display("FAIL midrst_pulses: got ferr=%b ovr=%b want 0/0", FRAME_ERR, OVERRUN); end
        send_bits(8'h80, 8'h80, 0, 7, 1'b1, 2);
        n_cmp++; if (SUM !== 9'h100) begin n_bad++; $display("FAIL midrst_next_sum: got %h want %h", SUM, 9'h100); end
        n_cmp++; if (r_fe_total !== 0) begin n_bad++; $display("FAIL midrst_no_ferr: got %0d want 0", r_fe_total); end
        drain();
    endtask

    task automatic test_random();
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        logic [SIZE:0]   exp;
        int unstable;
        for (int f = 0; f < 25; f++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            exp = sum_model(a, b);
            SUM_READY = 1'b0;
            send_bits(a, b, 0, 7, 1'b1, 3);
            n_cmp++; if (SUM !== exp) begin n_bad++; $display("FAIL rand_sum[%0d]: a=%h b=%h got %h want %h", f, a, b, SUM, exp); end
            n_cmp++; if (r_early !== 0) begin n_bad++; $display("FAIL rand_early[%0d]: got %0d want 0", f, r_early); end
`ifdef BSRX_SIGNED_OVF_EN
            n_cmp++; if (OVF !== ovf_model(a, b)) begin n_bad++; $display("FAIL rand_ovf[%0d]: got %b want %b", f, OVF, ovf_model(a, b)); end
`endif
            unstable = 0;
            repeat (int'($urandom_range(3, 0))) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b0);
                if (SUM !== exp || SUM_VALID !== 1'b1) unstable++;
            end
            n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL rand_hold[%0d]: got %0d unstable want 0", f, unstable); end
            drain();
        end
    endtask

`ifdef BSRX_SIGNED_OVF_EN
    task automatic test_ovf();
        SUM_READY = 1'b0;
        send_bits(8'h7F, 8'h01, 0, 7, 1'b1, 0);
        n_cmp++; if (OVF !== 1'b1) begin n_bad++; $display("FAIL ovf_pos: got %b want 1", OVF); end
        n_cmp++; if (SUM !== 9'h080) begin n_bad++; $display("FAIL ovf_pos_sum: got %h want %h", SUM, 9'h080); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (OVF !== 1'b1) begin n_bad++; $display("FAIL ovf_held: got %b want 1", OVF); end
        drain();
        send_bits(8'hFF, 8'h01, 0, 7, 1'b1, 0);
        n_cmp++; if (OVF !== 1'b0) begin n_bad++; $display("FAIL ovf_none: got %b want 0", OVF); end
        n_cmp++; if (SUM !== 9'h100) begin n_bad++; $display("FAIL ovf_none_sum: got %h want %h", SUM, 9'h100); end
        drain();
    endtask
`endif

    initial begin
        RST         = 1'b1;
        FRAME_START = 1'b0;
        BIT_VALID   = 1'b0;
        A_BIT       = 1'b0;
        B_BIT       = 1'b0;
        SUM_READY   = 1'b0;
        test_reset();
        test_basic();
        test_stalls();
        test_frame_err();
        test_overrun_back_to_back();
        test_reset_mid_frame();
        test_random();
`ifdef BSRX_SIGNED_OVF_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
